mips_multicycle_control: RTL and testbench

Main control state machine for the multi-cycle MIPS datapath. It sequences instruction fetch, register decode, execute, memory access and writeback. Each cycle it drives the strobes consumed by the register-file/decode stage (`ctrl_reg_dest`, `ctrl_reg_write`), the ALU muxes, memory and PC update logic. It also inserts wait states on memory and halts on an unsupported opcode.

---
 rtl/mips_multicycle_control_if.sv | 38 +++
 rtl/mips_multicycle_control.sv | 196 +++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_control_if.sv
// Control-to-datapath bundle for the multi-cycle MIPS control unit.
// The control unit is the master; the datapath supplies opcode/mem_ready.
interface mips_multicycle_control_if #(
  parameter int RETIRE_W = 16
);
  logic [5:0]          opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic [1:0]          pc_source;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                mem_to_reg;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic                ctrl_reg_dest;
  logic                ctrl_reg_write;
  logic                halted;
  logic [3:0]          state;
  logic [RETIRE_W-1:0] retired;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           ctrl_reg_dest, ctrl_reg_write, halted, state, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           ctrl_reg_dest, ctrl_reg_write, halted, state, retired
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main sequencer for the multi-cycle MIPS datapath: fetch, decode, execute,
// memory and writeback, with memory wait states and halt on unknown opcodes.
module mips_multicycle_control #(
  parameter int RETIRE_W = 16
) (
  input logic                         clk,
  input logic                         rst,
  mips_multicycle_control_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [RETIRE_W-1:0] retired_r;

  logic       pc_write_s;
  logic       pc_write_cond_s;
  logic [1:0] pc_source_s;
  logic       i_or_d_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       mem_to_reg_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic       ctrl_reg_dest_s;
  logic       ctrl_reg_write_s;
  logic       halted_s;

  // Next-state selection; opcode is only consulted in DECODE and MEM_ADDR.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_FETCH:    state_nxt_s = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:              state_nxt_s = S_R_EXEC;
          OP_LW, OP_SW, OP_ADDI: state_nxt_s = S_MEM_ADDR;
          OP_BEQ:                state_nxt_s = S_BRANCH;
          OP_J:                  state_nxt_s = S_JUMP;
          default:               state_nxt_s = S_HALT;
        endcase
      end
      S_MEM_ADDR: begin
        case (bus.opcode)
          OP_LW:   state_nxt_s = S_MEM_RD;
          OP_SW:   state_nxt_s = S_MEM_WR;
          OP_ADDI: state_nxt_s = S_ADDI_WB;
          default: state_nxt_s = S_HALT;
        endcase
      end
      S_MEM_RD:   state_nxt_s = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_nxt_s = bus.mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   state_nxt_s = S_R_WB;
      S_MEM_WB,
      S_R_WB,
      S_ADDI_WB,
      S_BRANCH,
      S_JUMP:     state_nxt_s = S_FETCH;
      S_HALT:     state_nxt_s = S_HALT;
      // Unused codes 11-14 land here and fall into HALT.
      default:    state_nxt_s = S_HALT;
    endcase
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_FETCH;
      retired_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r != S_FETCH) && (state_nxt_s == S_FETCH)) begin
        retired_r <= retired_r + RETIRE_W'(1);
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  // Moore strobe decode; gating with rst lets reset kill strobes without an edge.
  always_comb begin
    pc_write_s       = 1'b0;
    pc_write_cond_s  = 1'b0;
    pc_source_s      = 2'b00;
    i_or_d_s         = 1'b0;
    mem_read_s       = 1'b0;
    mem_write_s      = 1'b0;
    ir_write_s       = 1'b0;
    mem_to_reg_s     = 1'b0;
    alu_src_a_s      = 1'b0;
    alu_src_b_s      = 2'b00;
    alu_op_s         = 2'b00;
    ctrl_reg_dest_s  = 1'b0;
    ctrl_reg_write_s = 1'b0;
    halted_s         = 1'b0;
    if (rst) begin
      halted_s = 1'b0;
    end else begin
      case (state_r)
        S_FETCH: begin
          mem_read_s  = 1'b1;
          alu_src_b_s = 2'b01;
          ir_write_s  = bus.mem_ready;
          pc_write_s  = bus.mem_ready;
        end
        S_DECODE: begin
          alu_src_b_s = 2'b11;
        end
        S_MEM_ADDR: begin
          alu_src_a_s = 1'b1;
          alu_src_b_s = 2'b10;
        end
        S_MEM_RD: begin
          mem_read_s = 1'b1;
          i_or_d_s   = 1'b1;
        end
        S_MEM_WB: begin
          mem_to_reg_s     = 1'b1;
          ctrl_reg_write_s = 1'b1;
        end
        S_MEM_WR: begin
          mem_write_s = 1'b1;
          i_or_d_s    = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a_s = 1'b1;
          alu_op_s    = 2'b10;
        end
        S_R_WB: begin
          ctrl_reg_dest_s  = 1'b1;
          ctrl_reg_write_s = 1'b1;
        end
        S_ADDI_WB: begin
          ctrl_reg_write_s = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_s     = 1'b1;
          alu_op_s        = 2'b01;
          pc_write_cond_s = 1'b1;
          pc_source_s     = 2'b01;
        end
        S_JUMP: begin
          pc_write_s  = 1'b1;
          pc_source_s = 2'b10;
        end
        S_HALT: begin
          halted_s = 1'b1;
        end
        default: begin
          halted_s = 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_write       = pc_write_s;
  assign bus.pc_write_cond  = pc_write_cond_s;
  assign bus.pc_source      = pc_source_s;
  assign bus.i_or_d         = i_or_d_s;
  assign bus.mem_read       = mem_read_s;
  assign bus.mem_write      = mem_write_s;
  assign bus.ir_write       = ir_write_s;
  assign bus.mem_to_reg     = mem_to_reg_s;
  assign bus.alu_src_a      = alu_src_a_s;
  assign bus.alu_src_b      = alu_src_b_s;
  assign bus.alu_op         = alu_op_s;
  assign bus.ctrl_reg_dest  = ctrl_reg_dest_s;
  assign bus.ctrl_reg_write = ctrl_reg_write_s;
  assign bus.halted         = halted_s;
  assign bus.state          = state_r;
  assign bus.retired        = retired_r;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: per-cycle state and strobe
// vectors against hand-written expectations, plus a narrow-counter wrap run.
module tb_mips_multicycle_control;

  logic clk;
  logic rst;
  logic rst4;
  int   checks;
  int   errors;

  mips_multicycle_control_if #(.RETIRE_W(16)) bus ();
  mips_multicycle_control_if #(.RETIRE_W(4))  bus4 ();

  mips_multicycle_control #(.RETIRE_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  mips_multicycle_control #(.RETIRE_W(4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, alu_src_a, alu_src_b, alu_op, ctrl_reg_dest, ctrl_reg_write, halted}
  logic [16:0] obs_s;
  assign obs_s = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d,
                  bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg,
                  bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.ctrl_reg_dest,
                  bus.ctrl_reg_write, bus.halted};

  localparam logic [16:0] SV_ZERO    = 17'b0_0_00_0_0_0_0_0_0_00_00_0_0_0;
  localparam logic [16:0] SV_FETCH   = 17'b1_0_00_0_1_0_1_0_0_01_00_0_0_0;
  localparam logic [16:0] SV_FETCHW  = 17'b0_0_00_0_1_0_0_0_0_01_00_0_0_0;
  localparam logic [16:0] SV_DECODE  = 17'b0_0_00_0_0_0_0_0_0_11_00_0_0_0;
  localparam logic [16:0] SV_MADDR   = 17'b0_0_00_0_0_0_0_0_1_10_00_0_0_0;
  localparam logic [16:0] SV_MEMRD   = 17'b0_0_00_1_1_0_0_0_0_00_00_0_0_0;
  localparam logic [16:0] SV_MEMWB   = 17'b0_0_00_0_0_0_0_1_0_00_00_0_1_0;
  localparam logic [16:0] SV_MEMWR   = 17'b0_0_00_1_0_1_0_0_0_00_00_0_0_0;
  localparam logic [16:0] SV_REXEC   = 17'b0_0_00_0_0_0_0_0_1_00_10_0_0_0;
  localparam logic [16:0] SV_RWB     = 17'b0_0_00_0_0_0_0_0_0_00_00_1_1_0;
  localparam logic [16:0] SV_ADDIWB  = 17'b0_0_00_0_0_0_0_0_0_00_00_0_1_0;
  localparam logic [16:0] SV_BRANCH  = 17'b0_1_01_0_0_0_0_0_1_00_01_0_0_0;
  localparam logic [16:0] SV_JUMP    = 17'b1_0_10_0_0_0_0_0_0_00_00_0_0_0;
  localparam logic [16:0] SV_HALT    = 17'b0_0_00_0_0_0_0_0_0_00_00_0_0_1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: set mem_ready, check state and strobes mid-cycle, advance.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [16:0] sv,
                     input logic rdy);
    bus.mem_ready = rdy;
    @(negedge clk);
    chk({tag, "_state"}, 32'(bus.state), 32'(st));
    chk({tag, "_strobes"}, 32'(obs_s), 32'(sv));
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    rst4           = 1'b1;
    bus.opcode     = 6'b000000;
    bus.mem_ready  = 1'b1;
    bus4.opcode    = 6'b000010;
    bus4.mem_ready = 1'b1;

    // Reset state: FETCH code but every strobe forced low.
    @(negedge clk);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_strobes", 32'(obs_s), 32'(SV_ZERO));
    chk("rst_retired", 32'(bus.retired), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // R-type, mem_ready tied high.
    bus.opcode = 6'b000000;
    cyc("r_f", 4'd0, SV_FETCH, 1'b1);
    cyc("r_d", 4'd1, SV_DECODE, 1'b1);
    cyc("r_x", 4'd6, SV_REXEC, 1'b1);
    cyc("r_wb", 4'd7, SV_RWB, 1'b1);
    chk("r_retired", 32'(bus.retired), 32'd1);

    // lw with two wait cycles in MEM_RD.
    bus.opcode = 6'b100011;
    cyc("lw_f", 4'd0, SV_FETCH, 1'b1);
    cyc("lw_d", 4'd1, SV_DECODE, 1'b1);
    cyc("lw_a", 4'd2, SV_MADDR, 1'b1);
    cyc("lw_rd0", 4'd3, SV_MEMRD, 1'b0);
    cyc("lw_rd1", 4'd3, SV_MEMRD, 1'b0);
    cyc("lw_rd2", 4'd3, SV_MEMRD, 1'b1);
    cyc("lw_wb", 4'd4, SV_MEMWB, 1'b1);
    chk("lw_retired", 32'(bus.retired), 32'd2);

    // addi with one fetch wait cycle.
    bus.opcode = 6'b001000;
    cyc("ad_fw", 4'd0, SV_FETCHW, 1'b0);
    cyc("ad_f", 4'd0, SV_FETCH, 1'b1);
    cyc("ad_d", 4'd1, SV_DECODE, 1'b1);
    cyc("ad_a", 4'd2, SV_MADDR, 1'b1);
    cyc("ad_wb", 4'd10, SV_ADDIWB, 1'b1);

    // sw; opcode changes after MEM_ADDR must not matter. Then beq and j.
    bus.opcode = 6'b101011;
    cyc("sw_f", 4'd0, SV_FETCH, 1'b1);
    cyc("sw_d", 4'd1, SV_DECODE, 1'b1);
    cyc("sw_a", 4'd2, SV_MADDR, 1'b1);
    bus.opcode = 6'b111111;
    cyc("sw_w0", 4'd5, SV_MEMWR, 1'b0);
    cyc("sw_w1", 4'd5, SV_MEMWR, 1'b1);
    bus.opcode = 6'b000100;
    cyc("beq_f", 4'd0, SV_FETCH, 1'b1);
    cyc("beq_d", 4'd1, SV_DECODE, 1'b1);
    cyc("beq_b", 4'd8, SV_BRANCH, 1'b1);
    bus.opcode = 6'b000010;
    cyc("j_f", 4'd0, SV_FETCH, 1'b1);
    cyc("j_d", 4'd1, SV_DECODE, 1'b1);
    cyc("j_j", 4'd9, SV_JUMP, 1'b1);
    chk("mix_retired", 32'(bus.retired), 32'd6);

    // Unsupported opcode halts and stays halted regardless of mem_ready.
    bus.opcode = 6'b111111;
    cyc("h_f", 4'd0, SV_FETCH, 1'b1);
    cyc("h_d", 4'd1, SV_DECODE, 1'b1);
    for (int i = 0; i < 20; i++) begin
      bus.opcode = 6'(i);
      cyc("h_hold", 4'd15, SV_HALT, logic'(i[0]));
    end
    chk("h_retired", 32'(bus.retired), 32'd6);
    rst = 1'b1;
    #1;
    chk("h_rst_state", 32'(bus.state), 32'd0);
    chk("h_rst_strobes", 32'(obs_s), 32'(SV_ZERO));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // One j to make retired non-zero, then reset asynchronously during R_WB.
    bus.opcode = 6'b000010;
    cyc("j2_f", 4'd0, SV_FETCH, 1'b1);
    cyc("j2_d", 4'd1, SV_DECODE, 1'b1);
    cyc("j2_j", 4'd9, SV_JUMP, 1'b1);
    bus.opcode = 6'b000000;
    cyc("r2_f", 4'd0, SV_FETCH, 1'b1);
    cyc("r2_d", 4'd1, SV_DECODE, 1'b1);
    cyc("r2_x", 4'd6, SV_REXEC, 1'b1);
    @(negedge clk);
    chk("r2_wb_strobes", 32'(obs_s), 32'(SV_RWB));
    chk("r2_wb_retired", 32'(bus.retired), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_regwrite", 32'(bus.ctrl_reg_write), 32'd0);
    chk("arst_state", 32'(bus.state), 32'd0);
    chk("arst_retired", 32'(bus.retired), 32'd0);
    chk("arst_strobes", 32'(obs_s), 32'(SV_ZERO));
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("post_f", 4'd0, SV_FETCH, 1'b1);

    // Narrow counter: 17 jumps wrap a 4-bit retired count to 1.
    rst4 = 1'b0;
    for (int c = 1; c <= 51; c++) begin
      @(posedge clk);
      #1;
      if (c == 45) chk("w4_15", 32'(bus4.retired), 32'd15);
      else if (c == 48) chk("w4_wrap0", 32'(bus4.retired), 32'd0);
      else if (c == 51) chk("w4_wrap1", 32'(bus4.retired), 32'd1);
      else checks = checks;
    end
    chk("w4_state", 32'(bus4.state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
